// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared VRAM write-path widths, depth and write-entry type
package vram_pkg;

    localparam int VRAM_ADDR_W = 17;
    localparam int VRAM_DATA_W = 8;
    localparam int WFIFO_DEPTH = 16;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } vram_wr_t;

endpackage

// File: rtl/vram_wfifo_mem.sv
// rtl/vram_wfifo_mem.sv - simple dual-port RAM, registered read port, for the VRAM write FIFO
module vram_wfifo_mem
    import vram_pkg::*;
#(
    parameter  int DEPTH = WFIFO_DEPTH,
    parameter  int WIDTH = VRAM_ADDR_W + VRAM_DATA_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk100,
    input  logic             reset,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk100) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Read-before-write: a same-address push while full never bypasses into the pop
    always_ff @(posedge clk100) begin
        if (reset)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vram_write_fifo.sv
// rtl/vram_write_fifo.sv - CPU-to-VRAM write buffer with toggle handshake; VRAM_WFIFO_STATS_EN adds hwm/stall_cnt
module vram_write_fifo
    import vram_pkg::*;
#(
    parameter  int DEPTH  = WFIFO_DEPTH,
    parameter  int ADDR_W = VRAM_ADDR_W,
    parameter  int DATA_W = VRAM_DATA_W,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic              cpu_req_tgl,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_ack_tgl,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [PTR_W:0]    level,
    output logic              underflow
`ifdef VRAM_WFIFO_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [PTR_W:0]    hwm,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   LVL_ONE  = 1;
    localparam logic [PTR_W:0]   LVL_FULL = DEPTH;

    logic                     r_req_q;
    logic                     r_ack;
    logic [PTR_W-1:0]         r_wptr;
    logic [PTR_W-1:0]         r_rptr;
    logic [PTR_W:0]           r_level;
    logic                     r_underflow;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_req_pending;
    logic                     w_pop;
    logic                     w_push;
    logic [ADDR_W+DATA_W-1:0] w_rdata;

    assign w_empty       = (r_level == '0);
    assign w_full        = (r_level == LVL_FULL);
    assign w_req_pending = (r_req_q != r_ack);
    assign w_pop         = rd_en && !w_empty;
    // A full queue still accepts the pending write in the cycle a slot is freed
    assign w_push        = w_req_pending && (!w_full || w_pop);

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_req_q     <= 1'b0;
            r_ack       <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_req_q <= cpu_req_tgl;
            if (w_push) begin
                r_ack  <= r_req_q;
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop)
                r_rptr <= r_rptr + PTR_ONE;
            if (w_push && !w_pop)
                r_level <= r_level + LVL_ONE;
            else if (w_pop && !w_push)
                r_level <= r_level - LVL_ONE;
            if (rd_en && w_empty)
                r_underflow <= 1'b1;
        end
    end

    vram_wfifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_mem (
        .clk100  (clk100),
        .reset   (reset),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata ({cpu_addr, cpu_data}),
        .i_re    (w_pop),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign cpu_ack_tgl = r_ack;
    assign rd_addr     = w_rdata[ADDR_W+DATA_W-1:DATA_W];
    assign rd_data     = w_rdata[DATA_W-1:0];
    assign empty       = w_empty;
    assign full        = w_full;
    assign level       = r_level;
    assign underflow   = r_underflow;

`ifdef VRAM_WFIFO_STATS_EN
    logic [PTR_W:0] r_hwm;
    logic [15:0]    r_stall_cnt;

    always_ff @(posedge clk100) begin
        if (reset || stats_clr) begin
            r_hwm       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_level > r_hwm)
                r_hwm <= r_level;
            if (w_req_pending && w_full && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign hwm       = r_hwm;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vram_write_fifo.sv
// tb/tb_vram_write_fifo.sv - self-checking bench for vram_write_fifo against a queue reference model
module tb_vram_write_fifo;
    import vram_pkg::*;

    localparam int DEPTH = WFIFO_DEPTH;

    logic        clk100 = 1'b0;
    logic        reset;
    logic        cpu_req_tgl;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ack_tgl;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic        underflow;
`ifdef VRAM_WFIFO_STATS_EN
    logic        stats_clr;
    logic [4:0]  hwm;
    logic [15:0] stall_cnt;
`endif

    vram_write_fifo dut (
        .clk100      (clk100),
        .reset       (reset),
        .cpu_req_tgl (cpu_req_tgl),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_ack_tgl (cpu_ack_tgl),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .underflow   (underflow)
`ifdef VRAM_WFIFO_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .hwm         (hwm),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk100 = ~clk100;

    // Reference model: the queue holds accepted writes; the CPU request becomes visible one cycle late
    vram_wr_t    m_q[$];
    logic        m_req_q;
    logic        m_ack;
    logic        m_uf;
    logic [16:0] m_rd_addr;
    logic [7:0]  m_rd_data;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("ack", 32'(cpu_ack_tgl), 32'(m_ack));
        check("level", 32'(level), m_q.size());
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("full", 32'(full), 32'(m_q.size() == DEPTH));
        check("rd_addr", 32'(rd_addr), 32'(m_rd_addr));
        check("rd_data", 32'(rd_data), 32'(m_rd_data));
        check("underflow", 32'(underflow), 32'(m_uf));
    endtask

    task automatic step();
        bit       pop, push, uf;
        logic     req_pre;
        vram_wr_t e, front;
        pop     = rd_en && (m_q.size() != 0);
        push    = (m_req_q != m_ack) && ((m_q.size() < DEPTH) || pop);
        uf      = rd_en && (m_q.size() == 0);
        req_pre = cpu_req_tgl;
        e.addr  = cpu_addr;
        e.data  = cpu_data;
        @(posedge clk100);
        #1;
        if (pop) begin
            front     = m_q.pop_front();
            m_rd_addr = front.addr;
            m_rd_data = front.data;
        end
        if (push) begin
            m_q.push_back(e);
            m_ack = m_req_q;
        end
        if (uf)
            m_uf = 1'b1;
        m_req_q = req_pre;
        compare_all();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        cpu_req_tgl = 1'b0;
        rd_en       = 1'b0;
`ifdef VRAM_WFIFO_STATS_EN
        stats_clr   = 1'b0;
`endif
        @(posedge clk100);
        #1;
        reset = 1'b0;
        m_q.delete();
        m_req_q   = 1'b0;
        m_ack     = 1'b0;
        m_uf      = 1'b0;
        m_rd_addr = '0;
        m_rd_data = '0;
        compare_all();
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (cpu_ack_tgl != cpu_req_tgl && n < 40) begin
            step();
            n++;
        end
        if (cpu_ack_tgl != cpu_req_tgl)
            check("ack_timeout", 32'(cpu_ack_tgl), 32'(cpu_req_tgl));
    endtask

    task automatic write_blocking(input logic [16:0] a, input logic [7:0] d);
        cpu_addr    = a;
        cpu_data    = d;
        cpu_req_tgl = ~cpu_req_tgl;
        wait_ack();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] held;
        cpu_addr = '0;
        cpu_data = '0;
        do_reset();
        check("rst_level", 32'(level), 0);
        check("rst_empty", 32'(empty), 1);

        // 1: single write, ack within two cycles
        cpu_addr    = 17'h00123;
        cpu_data    = 8'hA5;
        cpu_req_tgl = 1'b1;
        step();
        step();
        check("t1_ack", 32'(cpu_ack_tgl), 1);
        check("t1_level", 32'(level), 1);
        check("t1_empty", 32'(empty), 0);

        // 2: one pop returns the write
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("t2_rd_addr", 32'(rd_addr), 32'h00123);
        check("t2_rd_data", 32'(rd_data), 32'hA5);
        check("t2_level", 32'(level), 0);
        check("t2_empty", 32'(empty), 1);

        // 3: fill, 17th write stalls until a pop frees a slot
        for (int i = 0; i < 16; i++)
            write_blocking(17'(i * 3 + 1), 8'(i));
        check("t3_full", 32'(full), 1);
        cpu_addr    = 17'h1FFFF;
        cpu_data    = 8'd16;
        cpu_req_tgl = ~cpu_req_tgl;
        for (int i = 0; i < 3; i++)
            step();
        check("t3_withheld", 32'(cpu_ack_tgl != cpu_req_tgl), 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("t3_acked", 32'(cpu_ack_tgl), 32'(cpu_req_tgl));
        check("t3_level", 32'(level), 16);
        check("t3_first", 32'(rd_data), 0);
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            step();
            check("t3_order", 32'(rd_data), i);
        end
        rd_en = 1'b0;

        // 4: push and pop together at level 5, pointers wrap
        for (int i = 0; i < 5; i++)
            write_blocking(17'($urandom), 8'($urandom));
        for (int i = 0; i < 20; i++) begin
            cpu_addr    = 17'($urandom);
            cpu_data    = 8'($urandom);
            cpu_req_tgl = ~cpu_req_tgl;
            step();
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
            check("t4_level", 32'(level), 5);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++)
            step();

        // 5: empty pop, then reset with a pending write
        held = rd_data;
        step();
        rd_en = 1'b0;
        check("t5_underflow", 32'(underflow), 1);
        check("t5_rd_data", 32'(rd_data), 32'(held));
        check("t5_level", 32'(level), 0);
        for (int i = 0; i < 7; i++)
            write_blocking(17'($urandom), 8'($urandom));
        cpu_req_tgl = ~cpu_req_tgl;
        step();
        do_reset();
        check("t5_rst_level", 32'(level), 0);
        check("t5_rst_uf", 32'(underflow), 0);
        for (int i = 0; i < 4; i++)
            step();
        check("t5_no_push", 32'(level), 0);

        // Random traffic: a filling phase then a draining phase
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 250; c++) begin
                if (cpu_ack_tgl == cpu_req_tgl && $urandom_range(0, 99) < 70) begin
                    cpu_addr    = 17'($urandom);
                    cpu_data    = 8'($urandom);
                    cpu_req_tgl = ~cpu_req_tgl;
                end
                rd_en = ($urandom_range(0, 99) < (ph == 0 ? 20 : 75));
                step();
            end
        end
        rd_en = 1'b0;
        wait_ack();

`ifdef VRAM_WFIFO_STATS_EN
        // 6: high-water mark and stall counting
        do_reset();
        for (int i = 0; i < 16; i++)
            write_blocking(17'(i), 8'(i));
        cpu_data    = 8'hEE;
        cpu_req_tgl = ~cpu_req_tgl;
        for (int i = 0; i < 11; i++)
            step();
        check("t6_hwm", 32'(hwm), 16);
        check("t6_stall", 32'(stall_cnt), 10);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check("t6_hwm_clr", 32'(hwm), 0);
        check("t6_stall_clr", 32'(stall_cnt), 0);
        rd_en = 1'b1;
        for (int i = 0; i < 17; i++)
            step();
        rd_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
